// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state type and length helpers for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    localparam int LEN_BYTES = 2;

    // A zero-length or oversized image can never be loaded without wrapping the address.
    function automatic logic len_invalid(input logic [8*LEN_BYTES-1:0] n, input int unsigned words);
        return (n == '0) || (32'(n) > words);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction memory write port out
interface imem_loader_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 6
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, we, waddr, wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_word_pack.sv
// rtl/imem_word_pack.sv - little-endian byte packer; first byte shifted in ends up in bits [7:0]
module imem_word_pack #(
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              clear,
    input  logic              shift,
    input  logic [7:0]        din,
    output logic [DWIDTH-1:0] word,
    output logic              last,
    output logic              full
);
    localparam int BYTES = DWIDTH / 8;
    localparam int CW    = $clog2(BYTES + 1);

    logic [CW-1:0]     cnt;
    logic [DWIDTH-1:0] shifted;

    generate
        if (BYTES > 1) begin : g_multi
            assign shifted = {din, word[DWIDTH-1:8]};
        end else begin : g_single
            assign shifted = din;
        end
    endgenerate

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (shift) begin
            word <= shifted;
            cnt  <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(BYTES - 1));
    assign full = (cnt == CW'(BYTES));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: length-prefixed byte frame into instruction memory, CPU hold control
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 6,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic          clock,
    input  logic          nReset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int unsigned WORDS = 1 << AWIDTH;

    ld_state_t         state, state_n;
    logic [15:0]       len_q;
    logic [AWIDTH:0]   index_q;
    logic              hold_q, err_q;
    logic [DWIDTH-1:0] packed_word;
    logic              pack_last, pack_full;

    logic xfer, last_word;
    logic load_lo, load_hi, pack_shift, pack_clear;
    logic idx_clr, idx_inc, set_err, begin_load, release_cpu;

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign last_word = (16'(index_q) == (len_q - 16'd1));

    imem_word_pack #(.DWIDTH(DWIDTH)) u_pack (
        .clock  (clock),
        .nReset (nReset),
        .clear  (pack_clear),
        .shift  (pack_shift),
        .din    (bus.rx_data),
        .word   (packed_word),
        .last   (pack_last),
        .full   (pack_full)
    );

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n     = state;
        load_lo     = 1'b0;
        load_hi     = 1'b0;
        pack_shift  = 1'b0;
        pack_clear  = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        set_err     = 1'b0;
        begin_load  = 1'b0;
        release_cpu = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                begin_load = 1'b1;
                pack_clear = 1'b1;
                idx_clr    = 1'b1;
                state_n    = ST_LEN_LO;
            end
            ST_LEN_LO: if (xfer) begin
                load_lo = 1'b1;
                state_n = ST_LEN_HI;
            end
            ST_LEN_HI: if (xfer) begin
                load_hi = 1'b1;
                if (len_invalid({bus.rx_data, len_q[7:0]}, WORDS)) begin
                    set_err = 1'b1;
                    state_n = ST_ERR;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: if (xfer) begin
                pack_shift = 1'b1;
                if (pack_last) state_n = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word) begin
                    release_cpu = 1'b1;
                    state_n     = ST_DONE;
                end else begin
                    idx_inc    = 1'b1;
                    pack_clear = 1'b1;
                    state_n    = ST_DATA;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            len_q   <= '0;
            index_q <= '0;
            hold_q  <= BOOT_HOLD;
            err_q   <= 1'b0;
        end else begin
            if (load_lo) len_q[7:0]  <= bus.rx_data;
            if (load_hi) len_q[15:8] <= bus.rx_data;
            if (idx_clr)      index_q <= '0;
            else if (idx_inc) index_q <= index_q + 1'b1;
            if (begin_load) begin
                hold_q <= 1'b1;
                err_q  <= 1'b0;
            end
            if (set_err)     err_q  <= 1'b1;
            if (release_cpu) hold_q <= 1'b0;
        end
    end

    // The packer is always full in WRITE; the extra term keeps a stray write impossible.
    assign bus.we       = (state == ST_WRITE) && pack_full;
    assign bus.waddr    = index_q[AWIDTH-1:0];
    assign bus.wdata    = packed_word;
    assign bus.rx_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign err          = err_q;
    assign cpu_hold     = hold_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader and boot sequencer for the instruction memory. Accepts a byte stream (UART receiver or debug bridge) with a valid/ready handshake, packs bytes little-endian into instruction words and writes them sequentially into the instruction memory write port. Holds the CPU in a hold state until a complete program has been written, then releases it.

## Interface
- `DWIDTH`, 32, instruction word width; must be a multiple of 8 (BYTES = DWIDTH/8).
- `AWIDTH`, 6, word address width; capacity WORDS = 1<<AWIDTH.
- `BOOT_HOLD`, 1, reset value of `cpu_hold`: 1 = CPU held until the first load completes; 0 = CPU runs from the preloaded image.
- `clock`  in  1  single clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  instruction memory write enable.
- `waddr`  out  AWIDTH  word address of the write.
- `wdata`  out  DWIDTH  packed instruction word.
- `cpu_hold`  out  1  1 = CPU held (PC frozen, no fetch).
- `busy`  out  1  load in progress (any state except IDLE).
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  bad length header; sticky until the next `start`.

## Operation
- A byte transfers on a cycle with `rx_valid && rx_ready`.
- Frame format: 2-byte word count N (low byte first), then N×BYTES data bytes. Within each word, byte 0 is bits [7:0].
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE: `rx_ready`=0. `start`=1 → LEN_LO, clear `err`, set `cpu_hold`=1, clear word index and byte count.
- LEN_LO: `rx_ready`=1. On transfer, latch N[7:0] → LEN_HI.
- LEN_HI: `rx_ready`=1. On transfer, latch N[15:8].
  - N=0 or N>WORDS → ERR.
  - Otherwise → DATA.
- DATA: `rx_ready`=1. Each transfer shifts the byte into the packer. On the BYTES-th byte → WRITE.
- WRITE: `rx_ready`=0, `we`=1, `waddr`=index, `wdata`=packed word.
  - If index == N-1 → DONE.
  - Otherwise index+1, byte count 0 → DATA.
- DONE: `done`=1 for one cycle, `cpu_hold`=0 → IDLE.
- ERR: `err`=1, `rx_ready`=0, `cpu_hold` stays 1 → IDLE. `err` holds until the next `start`.
- `start` outside IDLE is ignored. A `start` and `rx_valid` in the same IDLE cycle: the byte is not accepted.
- `rx_valid` low in any receive state: wait indefinitely, no timeout.
- Index is AWIDTH+1 bits internally. The N≤WORDS check guarantees `waddr` never wraps.

## Timing
- Reset values:
  - state IDLE
  - `rx_ready`=0, `we`=0, `waddr`=0, `wdata`=0
  - `cpu_hold`=BOOT_HOLD
  - `busy`=0, `done`=0, `err`=0
- Outputs are Moore, decoded from registered state/datapath. No combinational path from inputs to outputs.
- Minimum throughput: BYTES+1 cycles per word (BYTES accepts + 1 WRITE).
- `done` and `cpu_hold` falling occur in the cycle after the final WRITE cycle.
- Full load with `rx_valid` held high: 1 (IDLE→LEN_LO) + 2 + N×(BYTES+1) + 1 cycles from `start` to `done`.
- Reset mid-load: all outputs return to reset values immediately. Words already written remain in memory. `cpu_hold`=BOOT_HOLD.

## Structure
- Package `imem_loader_pkg`: state enum `ld_state_t`, `LEN_BYTES`=2.
- Sub-module `imem_word_pack`: BYTES-deep byte shift register with byte counter and `full` flag. Clear and shift inputs, DWIDTH output.
- Top level holds the FSM, index/length registers and output decode.

## Test plan
- N=2, bytes 02 00 | 13 05 10 00 | 93 05 20 00, `rx_valid` always high:
  - `we` at `waddr`=0 with `wdata`=0x00100513.
  - `we` at `waddr`=1 with `wdata`=0x00200593.
  - `done` at cycle 14 after `start`; `cpu_hold` falls with it.
- Same frame with `rx_valid` toggled every other cycle → identical writes, no byte lost or duplicated; `rx_ready` low in every WRITE cycle.
- Header 00 00 and header 41 00 (N=65 > 64) → `err`=1, no `we`, `cpu_hold` stays 1. Next `start` clears `err`.
- N=64 full image → last write at `waddr`=63, no wrap, `done` asserted.
- `nReset` low after 6 data bytes → all outputs reset, word 0 written, word 1 not. Restart loads correctly.
- `start` pulsed during DATA and in the same cycle as the first `rx_valid` → ignored / byte not consumed, frame still decodes correctly.
